sha256_job_arbiter: RTL and testbench



---
 rtl/sha256_pkg.sv | 7 +
 rtl/sha256_rr_pick.sv | 21 ++
 rtl/sha256_job_arbiter.sv | 122 ++++++++++++
 tb/tb_sha256_job_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and constants for the SHA-256 job arbiter.
package sha256_pkg;
  localparam int SHA256_ADDR_W = 16;
  localparam int SHA256_N_REQ = 4;
  localparam int SHA256_ID_W = 3;
  typedef enum logic [1:0] {IDLE, START, BUSY, RELEASE} sha256_arb_state_e;
endpackage

// File: rtl/sha256_rr_pick.sv
// sha256_rr_pick: round-robin find-first, searching upward from ptr+1 modulo N_REQ.
module sha256_rr_pick import sha256_pkg::*; #(
  parameter int N_REQ = SHA256_N_REQ
) (
  input  logic [N_REQ-1:0]       eligible,
  input  logic [SHA256_ID_W-1:0] ptr,
  output logic [SHA256_ID_W-1:0] winner,
  output logic                   valid
);
  logic [SHA256_ID_W-1:0] j;
  // Walk offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    winner = '0;
    j = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = SHA256_ID_W'((int'(ptr) + k) % N_REQ);
      winner = |(eligible & (N_REQ'(1) << j)) ? j : winner;
    end
  end
  assign valid = |eligible;
endmodule

// File: rtl/sha256_job_arbiter.sv
// sha256_job_arbiter: round-robin sharing of one simplified_sha256 core among N_REQ requesters.
// Define SHA256_ARB_TIMEOUT_EN to abort jobs whose core stays busy for TIMEOUT_CYCLES.
module sha256_job_arbiter import sha256_pkg::*; #(
  parameter int N_REQ = SHA256_N_REQ,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ*SHA256_ADDR_W-1:0]  req_msg_addr,
  input  logic [N_REQ*SHA256_ADDR_W-1:0]  req_out_addr,
  output logic [N_REQ-1:0]                ack,
  output logic [N_REQ-1:0]                err,
  output logic                            busy,
  output logic [SHA256_ID_W-1:0]          grant_id,
  output logic                            core_start,
  output logic [SHA256_ADDR_W-1:0]        core_message_addr,
  output logic [SHA256_ADDR_W-1:0]        core_output_addr,
  input  logic                            core_done,
  output logic                            core_reset_n
);
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("sha256_job_arbiter: parameter out of range");
  end
  sha256_arb_state_e state, state_d;
  logic [N_REQ-1:0] ignore, ignore_d, ack_d, err_d, set, onehot;
  logic [SHA256_ID_W-1:0] ptr, ptr_d, gid_d, pick;
  logic [SHA256_ADDR_W-1:0] maddr_d, oaddr_d;
  logic busy_d, start_d, crn_d, pick_valid, finish;
`ifdef SHA256_ARB_TIMEOUT_EN
  logic [15:0] cnt, cnt_d;
  assign finish = core_done | (cnt + 16'd1 == 16'(TIMEOUT_CYCLES));
`else
  assign finish = core_done;
`endif
  assign onehot = N_REQ'(1) << grant_id;
  sha256_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .eligible(req & ~ignore),
    .ptr(ptr),
    .winner(pick),
    .valid(pick_valid)
  );
  always_comb begin
    state_d = state;
    ack_d = '0;
    err_d = '0;
    busy_d = busy;
    gid_d = grant_id;
    start_d = 1'b0;
    maddr_d = core_message_addr;
    oaddr_d = core_output_addr;
    crn_d = 1'b1;
    ptr_d = ptr;
    set = '0;
`ifdef SHA256_ARB_TIMEOUT_EN
    cnt_d = cnt + 16'd1;
`endif
    case (state)
      IDLE: if (pick_valid) begin
        state_d = START;
        gid_d = pick;
        maddr_d = SHA256_ADDR_W'(req_msg_addr >> (SHA256_ADDR_W * int'(pick)));
        oaddr_d = SHA256_ADDR_W'(req_out_addr >> (SHA256_ADDR_W * int'(pick)));
        start_d = 1'b1;
        busy_d = 1'b1;
      end
      START: begin
        state_d = BUSY;
`ifdef SHA256_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      BUSY: if (finish) begin
        state_d = RELEASE;
        crn_d = 1'b0;
        ack_d = onehot;
        // A done arriving in the expiry cycle counts as a clean completion.
        err_d = core_done ? '0 : onehot;
      end
      RELEASE: begin
        state_d = IDLE;
        busy_d = 1'b0;
        ptr_d = grant_id;
        set = onehot;
      end
      default: state_d = IDLE;
    endcase
    ignore_d = (ignore | set) & req;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      ack <= '0;
      err <= '0;
      busy <= 1'b0;
      grant_id <= '0;
      core_start <= 1'b0;
      core_message_addr <= '0;
      core_output_addr <= '0;
      core_reset_n <= 1'b0;
      ptr <= SHA256_ID_W'(N_REQ - 1);
      ignore <= '0;
`ifdef SHA256_ARB_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      state <= state_d;
      ack <= ack_d;
      err <= err_d;
      busy <= busy_d;
      grant_id <= gid_d;
      core_start <= start_d;
      core_message_addr <= maddr_d;
      core_output_addr <= oaddr_d;
      core_reset_n <= crn_d;
      ptr <= ptr_d;
      ignore <= ignore_d;
`ifdef SHA256_ARB_TIMEOUT_EN
      cnt <= cnt_d;
`endif
    end
endmodule

// File: tb/tb_sha256_job_arbiter.sv
// tb_sha256_job_arbiter: randomized self-checking bench with a core stub and a round-robin reference model.
module tb_sha256_job_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*16-1:0] req_msg_addr = '0, req_out_addr = '0;
  logic [N-1:0] ack, err;
  logic busy, core_start, core_reset_n;
  logic [2:0] grant_id;
  logic [15:0] core_message_addr, core_output_addr;
  logic core_done = 1'b0;
  int vectors = 0, miscompares = 0;
  int done_delay = 20, stub_cnt = 0;
  bit stub_run = 0;
  int m_ptr = N - 1;
  bit [N-1:0] m_ign = '0;
  logic [15:0] msg [N], outa [N];

  sha256_job_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .req_msg_addr(req_msg_addr), .req_out_addr(req_out_addr),
    .ack(ack), .err(err), .busy(busy), .grant_id(grant_id),
    .core_start(core_start), .core_message_addr(core_message_addr),
    .core_output_addr(core_output_addr), .core_done(core_done),
    .core_reset_n(core_reset_n)
  );

  always #5 clk = ~clk;

  // Core stub: done rises done_delay cycles after the start cycle and stays up until core reset.
  always @(posedge clk) begin
    if (core_reset_n === 1'b0) begin
      core_done <= 1'b0;
      stub_run <= 0;
    end else if (core_start === 1'b1) begin
      stub_run <= 1;
      stub_cnt <= 1;
    end else if (stub_run) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == done_delay - 1) core_done <= 1'b1;
    end
  end

  function automatic int model_pick(logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int j = (m_ptr + k) % N;
      if (r[j] && !m_ign[j]) return j;
    end
    return -1;
  endfunction

  task automatic pack_addrs();
    for (int i = 0; i < N; i++) begin
      req_msg_addr[16*i +: 16] = msg[i];
      req_out_addr[16*i +: 16] = outa[i];
    end
  endtask

  task automatic set_addrs();
    for (int i = 0; i < N; i++) begin
      msg[i] = 16'($urandom);
      outa[i] = 16'($urandom);
    end
    pack_addrs();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_ptr = N - 1;
    m_ign = '0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (core_start !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (core_start !== 1'b1) n = -1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (ack === '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ack === '0) n = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = N'($urandom);
    repeat (3) @(negedge clk);
    vectors++; if (core_reset_n !== 1'b0) begin miscompares++; $display("FAIL rst_core_reset_n: got %b want 0", core_reset_n); end
    vectors++; if ({ack, err} !== '0) begin miscompares++; $display("FAIL rst_ack_err: got %h want 0", {ack, err}); end
    vectors++; if ({busy, core_start} !== 2'b00) begin miscompares++; $display("FAIL rst_busy_start: got %b want 00", {busy, core_start}); end
    vectors++; if ({grant_id, core_message_addr, core_output_addr} !== '0) begin miscompares++; $display("FAIL rst_id_addr: got %h want 0", {grant_id, core_message_addr, core_output_addr}); end
    req = '0;
    reset_n = 1'b1;
    @(negedge clk);
    vectors++; if (core_reset_n !== 1'b1) begin miscompares++; $display("FAIL rst_release_core: got %b want 1", core_reset_n); end
    m_ptr = N - 1;
    m_ign = '0;
  endtask

  task automatic test_single();
    int n;
    do_reset();
    set_addrs();
    msg[0] = 16'h0000;
    outa[0] = 16'h0100;
    pack_addrs();
    done_delay = 20;
    req = 4'b0001;
    @(negedge clk);
    vectors++; if (core_start !== 1'b1) begin miscompares++; $display("FAIL single_start_latency: got %b want 1", core_start); end
    vectors++; if (grant_id !== 3'd0) begin miscompares++; $display("FAIL single_gid: got %0d want 0", grant_id); end
    vectors++; if ({core_message_addr, core_output_addr} !== 32'h0000_0100) begin miscompares++; $display("FAIL single_addr: got %h want 00000100", {core_message_addr, core_output_addr}); end
    @(negedge clk);
    vectors++; if (core_start !== 1'b0) begin miscompares++; $display("FAIL single_start_pulse: got %b want 0", core_start); end
    wait_ack(n);
    vectors++; if (n !== 20) begin miscompares++; $display("FAIL single_ack_latency: got %0d want 20", n); end
    vectors++; if ({ack, err, core_reset_n, busy} !== 10'b0001_0000_01) begin miscompares++; $display("FAIL single_release: got %b want 0001000001", {ack, err, core_reset_n, busy}); end
    @(negedge clk);
    vectors++; if ({ack, core_reset_n, busy} !== 6'b0000_10) begin miscompares++; $display("FAIL single_idle: got %b want 000010", {ack, core_reset_n, busy}); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_rotate();
    int n, exp, nxt;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    set_addrs();
    req = '1;
    exp = model_pick(req);
    for (int r = 0; r < 5; r++) begin
      done_delay = $urandom_range(2, 12);
      wait_start(n);
      vectors++; if (grant_id !== 3'(order[r]) || int'(grant_id) != exp) begin miscompares++; $display("FAIL rot_gid[%0d]: got %0d want %0d", r, grant_id, order[r]); end
      vectors++; if ({core_message_addr, core_output_addr} !== {msg[exp], outa[exp]}) begin miscompares++; $display("FAIL rot_addr[%0d]: got %h want %h", r, {core_message_addr, core_output_addr}, {msg[exp], outa[exp]}); end
      wait_ack(n);
      vectors++; if (n != done_delay + 1 || ack !== N'(1 << exp)) begin miscompares++; $display("FAIL rot_ack[%0d]: got %b after %0d want %b after %0d", r, ack, n, N'(1 << exp), done_delay + 1); end
      m_ptr = exp;
      m_ign[exp] = 1;
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rot_busy[%0d]: got %b want 0", r, busy); end
      req[exp] = 1'b0;
      nxt = model_pick(req);
      m_ign[exp] = 0;
      @(negedge clk);
      req[exp] = 1'b1;
      exp = nxt;
    end
    req = '0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_hold();
    int n, starts;
    do_reset();
    set_addrs();
    req = 4'b0100;
    done_delay = 5;
    wait_start(n);
    vectors++; if (grant_id !== 3'd2) begin miscompares++; $display("FAIL hold_gid: got %0d want 2", grant_id); end
    wait_ack(n);
    vectors++; if (ack !== 4'b0100) begin miscompares++; $display("FAIL hold_ack: got %b want 0100", ack); end
    starts = 0;
    repeat (12) begin
      @(negedge clk);
      if (core_start !== 1'b0) starts++;
    end
    vectors++; if (starts != 0) begin miscompares++; $display("FAIL hold_no_regrant: got %0d starts want 0", starts); end
    req[2] = 1'b0;
    @(negedge clk);
    req[2] = 1'b1;
    wait_start(n);
    vectors++; if (n != 1 || grant_id !== 3'd2) begin miscompares++; $display("FAIL hold_regrant: got id %0d after %0d want id 2 after 1", grant_id, n); end
    wait_ack(n);
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_drop();
    int n;
    do_reset();
    set_addrs();
    req = 4'b0010;
    done_delay = $urandom_range(3, 15);
    wait_start(n);
    vectors++; if (grant_id !== 3'd1) begin miscompares++; $display("FAIL drop_gid: got %0d want 1", grant_id); end
    req = '0;
    wait_ack(n);
    vectors++; if (n != done_delay + 1 || ack !== 4'b0010) begin miscompares++; $display("FAIL drop_ack: got %b after %0d want 0010 after %0d", ack, n, done_delay + 1); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int n, exp;
    logic [N-1:0] v;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      set_addrs();
      v = N'($urandom_range(1, 15));
      exp = model_pick(v);
      done_delay = $urandom_range(2, 10);
      req = v;
      wait_start(n);
      vectors++; if (int'(grant_id) != exp || {core_message_addr, core_output_addr} !== {msg[exp], outa[exp]}) begin miscompares++; $display("FAIL rand_grant[%0d]: got id %0d addr %h want id %0d addr %h", r, grant_id, {core_message_addr, core_output_addr}, exp, {msg[exp], outa[exp]}); end
      wait_ack(n);
      vectors++; if (ack !== N'(1 << exp) || err !== '0) begin miscompares++; $display("FAIL rand_ack[%0d]: got %b/%b want %b/0000", r, ack, err, N'(1 << exp)); end
      m_ptr = exp;
      @(negedge clk);
      req = '0;
      m_ign = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_job();
    int n;
    do_reset();
    set_addrs();
    req = 4'b1000;
    done_delay = 50;
    wait_start(n);
    vectors++; if (grant_id !== 3'd3) begin miscompares++; $display("FAIL mid_gid: got %0d want 3", grant_id); end
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    req = 4'b1001;
    @(negedge clk);
    vectors++; if ({core_reset_n, ack, err, busy, core_start} !== '0) begin miscompares++; $display("FAIL mid_reset_outs: got %b want 0", {core_reset_n, ack, err, busy, core_start}); end
    vectors++; if ({grant_id, core_message_addr, core_output_addr} !== '0) begin miscompares++; $display("FAIL mid_reset_regs: got %h want 0", {grant_id, core_message_addr, core_output_addr}); end
    done_delay = 4;
    reset_n = 1'b1;
    m_ptr = N - 1;
    m_ign = '0;
    wait_start(n);
    vectors++; if (int'(grant_id) != model_pick(4'b1001) || grant_id !== 3'd0) begin miscompares++; $display("FAIL mid_next_gid: got %0d want 0", grant_id); end
    wait_ack(n);
    vectors++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL mid_ack: got %b want 0001", ack); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    set_addrs();
    req = 4'b0010;
`ifdef SHA256_ARB_TIMEOUT_EN
    done_delay = -1;
    wait_start(n);
    vectors++; if (grant_id !== 3'd1) begin miscompares++; $display("FAIL to_gid: got %0d want 1", grant_id); end
    wait_ack(n);
    vectors++; if (n != 65) begin miscompares++; $display("FAIL to_latency: got %0d want 65", n); end
    vectors++; if ({ack, err, core_reset_n} !== 9'b0010_0010_0) begin miscompares++; $display("FAIL to_flags: got %b want 001000100", {ack, err, core_reset_n}); end
    @(negedge clk);
    vectors++; if ({ack, err} !== '0) begin miscompares++; $display("FAIL to_pulse: got %b want 0", {ack, err}); end
    req = '0;
    repeat (2) @(negedge clk);
    req = 4'b0010;
    done_delay = 64;
    wait_start(n);
    wait_ack(n);
    vectors++; if (n != 65 || ack !== 4'b0010 || err !== 4'b0000) begin miscompares++; $display("FAIL to_done_wins: got %b/%b after %0d want 0010/0000 after 65", ack, err, n); end
`else
    done_delay = 100;
    wait_start(n);
    wait_ack(n);
    vectors++; if (n != 101 || ack !== 4'b0010 || err !== 4'b0000) begin miscompares++; $display("FAIL long_job: got %b/%b after %0d want 0010/0000 after 101", ack, err, n); end
`endif
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_hold();
    test_drop();
    test_random();
    test_reset_mid_job();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
